eth_clk_div_ctrl: RTL and testbench

ETH_CLK_DIV_CTRL -- requirements
Module: eth_clk_div_ctrl

---
 rtl/eth_clk_div_ctrl.sv | 139 +++++++++++++
 tb/tb_eth_clk_div_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_clk_div_ctrl.sv
// Ethernet speed-change sequencer: gates the divider output, programs a new divider value,
// then waits for it to settle. Define ETH_CLK_CTRL_TIMEOUT_EN to add a PROG handshake timeout.
module eth_clk_div_ctrl #(
   parameter int DIV_WIDTH     = 8,
   parameter int DIV_1G        = 4,
   parameter int DIV_100M      = 20,
   parameter int DIV_10M       = 200,
   parameter int GATE_CYCLES   = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [1:0]           speed_i,
   input  logic                 speed_valid_i,
   output logic                 speed_ready_o,
   output logic [DIV_WIDTH-1:0] div_o,
   output logic                 div_valid_o,
   input  logic                 div_ready_i,
   output logic                 clk_en_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [1:0]           cur_speed_o
);

   typedef enum logic [1:0] {IDLE, GATE, PROG, SETTLE} state_t;

   localparam logic [1:0] SPD_10M  = 2'b00;
   localparam logic [1:0] SPD_100M = 2'b01;
   localparam logic [1:0] SPD_1G   = 2'b10;
   localparam logic [1:0] SPD_RSVD = 2'b11;

   localparam logic [7:0] GATE_LAST   = 8'(GATE_CYCLES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
`ifdef ETH_CLK_CTRL_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'd254;
`endif

   state_t     state;
   logic [7:0] cnt;
   logic [1:0] target;

   function automatic logic [DIV_WIDTH-1:0] div_for(input logic [1:0] spd);
      case (spd)
         SPD_10M:  div_for = DIV_WIDTH'(DIV_10M);
         SPD_100M: div_for = DIV_WIDTH'(DIV_100M);
         default:  div_for = DIV_WIDTH'(DIV_1G);
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         cnt           <= '0;
         target        <= SPD_1G;
         speed_ready_o <= 1'b0;
         div_o         <= div_for(SPD_1G);
         div_valid_o   <= 1'b0;
         clk_en_o      <= 1'b1;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
         cur_speed_o   <= SPD_1G;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               speed_ready_o <= 1'b1;
               if (speed_valid_i && speed_ready_o) begin
                  if (speed_i == SPD_RSVD) begin
                     err_o <= 1'b1;
                  end else if (speed_i == cur_speed_o) begin
                     done_o <= 1'b1;
                  end else begin
                     target        <= speed_i;
                     state         <= GATE;
                     cnt           <= '0;
                     clk_en_o      <= 1'b0;
                     busy_o        <= 1'b1;
                     speed_ready_o <= 1'b0;
                  end
               end
            end

            GATE: begin
               if (cnt == GATE_LAST) begin
                  state       <= PROG;
                  cnt         <= '0;
                  div_o       <= div_for(target);
                  div_valid_o <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            // Divider output stays gated until the new value is actually taken.
            PROG: begin
               if (div_ready_i) begin
                  state       <= SETTLE;
                  cnt         <= '0;
                  div_valid_o <= 1'b0;
                  cur_speed_o <= target;
                  clk_en_o    <= 1'b1;
               end
`ifdef ETH_CLK_CTRL_TIMEOUT_EN
               else if (cnt == TIMEOUT_LAST) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  div_valid_o   <= 1'b0;
                  div_o         <= div_for(cur_speed_o);
                  clk_en_o      <= 1'b1;
                  busy_o        <= 1'b0;
                  speed_ready_o <= 1'b1;
                  err_o         <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end

            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  busy_o        <= 1'b0;
                  speed_ready_o <= 1'b1;
                  done_o        <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_clk_div_ctrl.sv
// Directed bench for eth_clk_div_ctrl: expected divider handshakes and done/err pulses are
// queued by the stimulus and retired by an independent monitor.
module tb_eth_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] speed = 2'b00;
   logic       speed_valid = 1'b0;
   logic       speed_ready;
   logic [7:0] div;
   logic       div_valid;
   logic       div_ready = 1'b1;
   logic       clk_en;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] cur_speed;

   eth_clk_div_ctrl dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .speed_i       (speed),
      .speed_valid_i (speed_valid),
      .speed_ready_o (speed_ready),
      .div_o         (div),
      .div_valid_o   (div_valid),
      .div_ready_i   (div_ready),
      .clk_en_o      (clk_en),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .cur_speed_o   (cur_speed)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {EV_DIV, EV_DONE, EV_ERR} ev_kind_t;
   typedef struct packed {
      ev_kind_t   kind;
      logic [7:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input ev_kind_t kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = 8'(val);
      exp_q.push_back(e);
   endtask

   task automatic retire(input ev_kind_t kind, input int val, input string nm);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_unexpected: event value %0d seen, queue empty (t=%0t)", nm, val, $time);
      end else begin
         e = exp_q.pop_front();
         check({nm, "_kind"}, int'(kind), int'(e.kind));
         check({nm, "_value"}, val, int'(e.val));
      end
   endtask

   // Monitor: retires one queued expectation per observed output event.
   always @(negedge clk) begin
      if (rst_n) begin
         if (div_valid && div_ready) retire(EV_DIV, int'(div), "div_handshake");
         if (done) retire(EV_DONE, int'(cur_speed), "done_pulse");
         if (err) retire(EV_ERR, int'(cur_speed), "err_pulse");
         if (done || err) check("done_err_exclusive", int'(done && err), 0);
      end
   end

   task automatic request(input logic [1:0] spd);
      int budget = 600;
      while (!speed_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("request_ready", int'(speed_ready), 1);
      speed       = spd;
      speed_valid = 1'b1;
      @(posedge clk); #1;
      speed_valid = 1'b0;
   endtask

   task automatic wait_div_valid(output int seen);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_valid) begin
            seen = 1;
            break;
         end
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int gated, lat, seen, bad_div, bad_en, bad_rdy, prog;

      // Reset state, held and released asynchronously
      repeat (3) @(negedge clk);
      check("rst_div", int'(div), 4);
      check("rst_cur_speed", int'(cur_speed), 2);
      check("rst_clk_en", int'(clk_en), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_div_valid", int'(div_valid), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_speed_ready", int'(speed_ready), 1);
      check("rel_div", int'(div), 4);
      check("rel_cur_speed", int'(cur_speed), 2);
      check("rel_clk_en", int'(clk_en), 1);

      // Reserved speed, then a request for the speed already active
      push(EV_ERR, 2);
      request(2'b11);
      @(negedge clk);
      check("rsvd_div", int'(div), 4);
      check("rsvd_cur_speed", int'(cur_speed), 2);
      check("rsvd_busy", int'(busy), 0);
      check("rsvd_ready", int'(speed_ready), 1);
      push(EV_DONE, 2);
      @(posedge clk); #1;
      request(2'b10);
      @(negedge clk);
      check("same_busy", int'(busy), 0);
      check("same_div_valid", int'(div_valid), 0);
      check("same_clk_en", int'(clk_en), 1);
      @(negedge clk);
      check("q_after_err_done", exp_q.size(), 0);

      // 1G -> 100M with a zero-wait divider
      @(posedge clk); #1;
      div_ready = 1'b1;
      push(EV_DIV, 20);
      push(EV_DONE, 1);
      request(2'b01);
      gated = 0;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (div_valid) begin
            seen = 1;
            break;
         end
         if (!clk_en) gated++;
      end
      check("m100_prog_seen", seen, 1);
      check("m100_gated_cycles", gated, 4);
      check("m100_prog_div", int'(div), 20);
      check("m100_busy", int'(busy), 1);
      check("m100_ready_low", int'(speed_ready), 0);
      @(negedge clk);
      check("m100_valid_one_cycle", int'(div_valid), 0);
      check("m100_clk_en_back", int'(clk_en), 1);
      wait_done(lat);
      check("m100_settle_latency", lat, 16);
      check("m100_cur_speed", int'(cur_speed), 1);
      check("m100_busy_idle", int'(busy), 0);

      // 100M -> 10M with the divider stalling for 50 cycles
      @(posedge clk); #1;
      div_ready = 1'b0;
      push(EV_DIV, 200);
      push(EV_DONE, 0);
      request(2'b00);
      wait_div_valid(seen);
      check("m10_prog_seen", seen, 1);
      bad_div = 0;
      bad_en  = 0;
      bad_rdy = 0;
      for (int i = 0; i < 50; i++) begin
         if (i > 0) @(negedge clk);
         if (div != 8'd200 || !div_valid) bad_div++;
         if (clk_en) bad_en++;
         if (speed_ready) bad_rdy++;
      end
      check("m10_div_stable_bad_cycles", bad_div, 0);
      check("m10_clk_en_low_bad_cycles", bad_en, 0);
      check("m10_ready_low_bad_cycles", bad_rdy, 0);
      @(posedge clk); #1;
      div_ready = 1'b1;
      wait_done(lat);
      check("m10_done_seen", int'(done), 1);
      check("m10_cur_speed", int'(cur_speed), 0);
      check("m10_div_held", int'(div), 200);

      // Reset asserted mid-SETTLE
      @(posedge clk); #1;
      push(EV_DIV, 20);
      request(2'b01);
      wait_div_valid(seen);
      check("rstmid_prog_seen", seen, 1);
      repeat (3) @(negedge clk);
      check("rstmid_pre_cur_speed", int'(cur_speed), 1);
      check("rstmid_pre_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_div", int'(div), 4);
      check("rstmid_cur_speed", int'(cur_speed), 2);
      check("rstmid_clk_en", int'(clk_en), 1);
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_div_valid", int'(div_valid), 0);
      check("rstmid_done", int'(done), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rstmid_rel_ready", int'(speed_ready), 1);

`ifdef ETH_CLK_CTRL_TIMEOUT_EN
      // Divider never answers: PROG gives up after 255 cycles
      div_ready = 1'b0;
      push(EV_ERR, 2);
      request(2'b01);
      wait_div_valid(seen);
      check("tmo_prog_seen", seen, 1);
      prog = 0;
      while (div_valid && prog < 400) begin
         prog++;
         @(negedge clk);
      end
      check("tmo_prog_cycles", prog, 255);
      check("tmo_err", int'(err), 1);
      check("tmo_div_restored", int'(div), 4);
      check("tmo_cur_speed", int'(cur_speed), 2);
      check("tmo_clk_en", int'(clk_en), 1);
      check("tmo_busy", int'(busy), 0);
      @(posedge clk); #1;
      div_ready = 1'b1;
`else
      prog = 0;
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
